write_grant_ctl: RTL and testbench

Downstream stage of the write arbiter core. It takes the core's 4-bit `select` and locks the grant onto the chosen input port for one whole packet. It streams that port's words to the SRAM write path under a valid/ready handshake, then reports completion (port, length) so the arbiter can advance its WRR state. Packets longer than `max_len` are truncated, and their remainder is drained.

---
 rtl/write_arbiter_pkg.sv | 17 +
 rtl/write_grant_ctl_port_mux.sv | 34 +++
 rtl/write_grant_ctl.sv | 174 +++++++++++++++++
 tb/tb_write_grant_ctl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_arbiter_pkg.sv
// Shared definitions for the write arbiter: grant FSM encoding, port index width
// and default packet-length limits.
package write_arbiter_pkg;

    localparam int unsigned PORT_W      = 4;
    localparam int unsigned DEF_MAX_LEN = 256;
    localparam int unsigned DEF_LEN_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOCK  = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } grant_state_e;

endpackage

// File: rtl/write_grant_ctl_port_mux.sv
// N:1 selection of the locked port's valid/data/eop plus one-hot pop decode.
module port_mux
    import write_arbiter_pkg::*;
#(
    parameter int unsigned num_of_ports = 16,
    parameter int unsigned data_width   = 32
) (
    input  logic [PORT_W-1:0]                    sel_i,
    input  logic                                 ready_en_i,
    input  logic [num_of_ports-1:0]              in_valid_i,
    input  logic [num_of_ports*data_width-1:0]   in_data_i,
    input  logic [num_of_ports-1:0]              in_eop_i,
    output logic                                 valid_o,
    output logic [data_width-1:0]                data_o,
    output logic                                 eop_o,
    output logic [num_of_ports-1:0]              in_ready_o
);

    always_comb begin
        valid_o    = 1'b0;
        data_o     = '0;
        eop_o      = 1'b0;
        in_ready_o = '0;
        for (int unsigned i = 0; i < num_of_ports; i++) begin
            if (sel_i == PORT_W'(i)) begin
                valid_o       = in_valid_i[i];
                data_o        = in_data_i[i*data_width +: data_width];
                eop_o         = in_eop_i[i];
                in_ready_o[i] = ready_en_i;
            end
        end
    end

endmodule

// File: rtl/write_grant_ctl.sv
// Locks the arbiter's selected port for one packet, streams it to the SRAM write
// path, truncates at max_len (draining the rest) and reports completion.
module write_grant_ctl
    import write_arbiter_pkg::*;
#(
    parameter int unsigned num_of_ports = 16,
    parameter int unsigned data_width   = 32,
    parameter int unsigned max_len      = DEF_MAX_LEN,
    parameter int unsigned len_w        = DEF_LEN_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [num_of_ports-1:0]              sop_i,
    input  logic [PORT_W-1:0]                    select_i,
    input  logic [num_of_ports-1:0]              in_valid_i,
    input  logic [num_of_ports*data_width-1:0]   in_data_i,
    input  logic [num_of_ports-1:0]              in_eop_i,
    output logic [num_of_ports-1:0]              in_ready_o,
    output logic                                 arb_hold_o,
    output logic                                 wr_valid_o,
    output logic                                 wr_sop_o,
    output logic                                 wr_eop_o,
    output logic [data_width-1:0]                wr_data_o,
    output logic [PORT_W-1:0]                    wr_port_o,
    input  logic                                 wr_ready_i,
    output logic                                 done_valid_o,
    output logic [PORT_W-1:0]                    done_port_o,
    output logic [len_w-1:0]                     done_len_o,
    output logic                                 done_trunc_o
);

    grant_state_e             state_q, state_d;
    logic [PORT_W-1:0]        port_q, port_d;
    logic [len_w-1:0]         cnt_q, cnt_d;
    logic                     first_q, first_d;
    logic                     trunc_q, trunc_d;
    logic                     arb_hold_q, arb_hold_d;
    logic                     done_valid_q, done_valid_d;
    logic [PORT_W-1:0]        done_port_q, done_port_d;
    logic [len_w-1:0]         done_len_q, done_len_d;
    logic                     done_trunc_q, done_trunc_d;

    logic                     grant_ok;
    logic                     ready_en;
    logic                     mux_valid;
    logic                     mux_eop;
    logic [data_width-1:0]    mux_data;
    logic                     at_max;

    port_mux #(
        .num_of_ports (num_of_ports),
        .data_width   (data_width)
    ) u_port_mux (
        .sel_i      (port_q),
        .ready_en_i (ready_en),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_eop_i   (in_eop_i),
        .valid_o    (mux_valid),
        .data_o     (mux_data),
        .eop_o      (mux_eop),
        .in_ready_o (in_ready_o)
    );

    // A grant needs an in-range select whose own sop bit is set.
    always_comb begin
        grant_ok = 1'b0;
        for (int unsigned i = 0; i < num_of_ports; i++) begin
            if (select_i == PORT_W'(i) && sop_i[i]) begin
                grant_ok = 1'b1;
            end
        end
    end

    assign at_max = (cnt_q == len_w'(max_len - 1));

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        trunc_d    = trunc_q;
        ready_en   = 1'b0;
        wr_valid_o = 1'b0;
        wr_sop_o   = 1'b0;
        wr_eop_o   = 1'b0;
        wr_data_o  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    port_d  = select_i;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                cnt_d   = '0;
                first_d = 1'b1;
                state_d = ST_XFER;
            end
            ST_XFER: begin
                ready_en   = wr_ready_i;
                wr_valid_o = mux_valid;
                wr_data_o  = mux_data;
                wr_sop_o   = first_q;
                wr_eop_o   = mux_eop | at_max;
                if (mux_valid && wr_ready_i) begin
                    first_d = 1'b0;
                    cnt_d   = cnt_q + len_w'(1);
                    // eop on the max_len-th word is a normal completion
                    if (mux_eop) begin
                        state_d = ST_DONE;
                    end else if (at_max) begin
                        trunc_d = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                ready_en = 1'b1;
                if (mux_valid && mux_eop) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                trunc_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arb_hold_d   = (state_d != ST_IDLE);
        done_valid_d = (state_d == ST_DONE);
        done_port_d  = done_valid_d ? port_d  : '0;
        done_len_d   = done_valid_d ? cnt_d   : '0;
        done_trunc_d = done_valid_d ? trunc_d : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            port_q       <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            trunc_q      <= 1'b0;
            arb_hold_q   <= 1'b0;
            done_valid_q <= 1'b0;
            done_port_q  <= '0;
            done_len_q   <= '0;
            done_trunc_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            trunc_q      <= trunc_d;
            arb_hold_q   <= arb_hold_d;
            done_valid_q <= done_valid_d;
            done_port_q  <= done_port_d;
            done_len_q   <= done_len_d;
            done_trunc_q <= done_trunc_d;
        end
    end

    assign wr_port_o    = port_q;
    assign arb_hold_o   = arb_hold_q;
    assign done_valid_o = done_valid_q;
    assign done_port_o  = done_port_q;
    assign done_len_o   = done_len_q;
    assign done_trunc_o = done_trunc_q;

endmodule

// File: tb/tb_write_grant_ctl.sv
// Randomised bench for write_grant_ctl against a packet-level scoreboard model,
// plus directed timing and boundary checks.
module tb_write_grant_ctl;

    localparam int unsigned NP   = 8;
    localparam int unsigned W    = 32;
    localparam int unsigned MAXL = 5;
    localparam int unsigned LW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   sop = '0;
    logic [3:0]      select = '0;
    logic [NP-1:0]   in_valid = '0;
    logic [NP*W-1:0] in_data = '0;
    logic [NP-1:0]   in_eop = '0;
    logic            wr_ready = 1'b0;

    logic [NP-1:0]   in_ready;
    logic            arb_hold, wr_valid, wr_sop, wr_eop;
    logic [W-1:0]    wr_data;
    logic [3:0]      wr_port;
    logic            done_valid;
    logic [3:0]      done_port;
    logic [LW-1:0]   done_len;
    logic            done_trunc;

    write_grant_ctl #(
        .num_of_ports (NP),
        .data_width   (W),
        .max_len      (MAXL),
        .len_w        (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sop_i        (sop),
        .select_i     (select),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_eop_i     (in_eop),
        .in_ready_o   (in_ready),
        .arb_hold_o   (arb_hold),
        .wr_valid_o   (wr_valid),
        .wr_sop_o     (wr_sop),
        .wr_eop_o     (wr_eop),
        .wr_data_o    (wr_data),
        .wr_port_o    (wr_port),
        .wr_ready_i   (wr_ready),
        .done_valid_o (done_valid),
        .done_port_o  (done_port),
        .done_len_o   (done_len),
        .done_trunc_o (done_trunc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus knobs
    int         valid_pct  = 100;
    int         ready_pct  = 100;
    int         ready_mode = 0;
    logic [3:0] rpat       = 4'b1001;
    int         kcnt       = 0;

    // packet-level model
    bit         busy = 1'b0;
    int         act  = 0;
    int         pend_port[$];
    int         pend_len[$];
    logic [W-1:0] src_data[$];
    bit         src_eop[$];
    logic [W-1:0] exp_data[$];
    bit         exp_sop[$];
    bit         exp_eop[$];
    int         exp_len = 0;
    int         exp_trunc = 0;
    int         serial = 0;
    int         done_cnt = 0;

    int first_wv_cyc = -1, last_sop_cyc = -1, last_eop_cyc = -1, done_cyc = -100;
    int hold_rise_cyc = -1, hold_fall_cyc = -1, drain_cnt = 0;
    bit prev_hold = 1'b0;
    int last_done_port = -1, last_done_len = -1, last_done_trunc = -1;
    int g = 0, eop1 = 0;

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act_v, exp_v);
        end
    endtask

    task automatic activate();
        int p, l, n;
        p = pend_port.pop_front();
        l = pend_len.pop_front();
        n = (l < int'(MAXL)) ? l : int'(MAXL);
        for (int i = 0; i < l; i++) begin
            logic [W-1:0] d;
            d = {8'(p), 24'(serial)};
            serial++;
            src_data.push_back(d);
            src_eop.push_back(i == l - 1);
            if (i < n) begin
                exp_data.push_back(d);
                exp_sop.push_back(i == 0);
                exp_eop.push_back(i == n - 1);
            end
        end
        exp_len      = n;
        exp_trunc    = (l > int'(MAXL)) ? 1 : 0;
        act          = p;
        busy         = 1'b1;
        first_wv_cyc = -1;
        drain_cnt    = 0;
    endtask

    // compare process: outputs are settled at the falling edge
    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            pend_port.delete(); pend_len.delete();
            src_data.delete(); src_eop.delete();
            exp_data.delete(); exp_sop.delete(); exp_eop.delete();
            prev_hold = 1'b0;
            chk("rst_outputs", 64'({in_ready, arb_hold, wr_valid, wr_sop, wr_eop, wr_port,
                                   done_valid, done_port, done_len, done_trunc}), 64'd0);
        end else begin
            if (arb_hold && !prev_hold) hold_rise_cyc = cyc;
            if (!arb_hold && prev_hold) hold_fall_cyc = cyc;
            prev_hold = arb_hold;
            if (busy) begin
                chk("in_ready_other", 64'(in_ready & ~(NP'(1) << act)), 64'd0);
                if (wr_valid) begin
                    if (first_wv_cyc < 0) first_wv_cyc = cyc;
                    chk("wr_port", 64'(wr_port), 64'(act));
                    chk("wr_valid_src", 64'(in_valid[act]), 64'd1);
                    if (src_data.size() > 0) chk("wr_data_mux", 64'(wr_data), 64'(src_data[0]));
                    if (wr_ready) begin
                        chk("beat_expected", 64'(exp_data.size() > 0), 64'd1);
                        chk("beat_pops", 64'(in_ready[act]), 64'd1);
                        if (exp_data.size() > 0) begin
                            chk("beat_data", 64'(wr_data), 64'(exp_data[0]));
                            chk("beat_sop", 64'(wr_sop), 64'(exp_sop[0]));
                            chk("beat_eop", 64'(wr_eop), 64'(exp_eop[0]));
                            void'(exp_data.pop_front());
                            void'(exp_sop.pop_front());
                            void'(exp_eop.pop_front());
                        end
                        if (wr_sop) last_sop_cyc = cyc;
                        if (wr_eop) last_eop_cyc = cyc;
                    end
                end
                if (in_ready[act] && exp_data.size() > 0) chk("ready_tracks", 64'(wr_ready), 64'd1);
                if (in_ready[act] && in_valid[act]) begin
                    chk("pop_nonempty", 64'(src_data.size() > 0), 64'd1);
                    if (src_data.size() > 0) begin
                        void'(src_data.pop_front());
                        void'(src_eop.pop_front());
                    end
                    if (!wr_valid) begin
                        chk("drain_after_fwd", 64'(exp_data.size()), 64'd0);
                        drain_cnt++;
                    end
                end
                if (done_valid) begin
                    chk("done_port", 64'(done_port), 64'(act));
                    chk("done_len", 64'(done_len), 64'(exp_len));
                    chk("done_trunc", 64'(done_trunc), 64'(exp_trunc));
                    chk("done_src_empty", 64'(src_data.size()), 64'd0);
                    chk("done_fwd_empty", 64'(exp_data.size()), 64'd0);
                    chk("done_hold", 64'(arb_hold), 64'd1);
                    last_done_port  = int'(done_port);
                    last_done_len   = int'(done_len);
                    last_done_trunc = int'(done_trunc);
                    done_cyc = cyc;
                    done_cnt++;
                    busy = 1'b0;
                end
            end else begin
                chk("idle_quiet", 64'({in_ready, wr_valid, done_valid}), 64'd0);
                if (cyc > done_cyc) chk("idle_hold", 64'(arb_hold), 64'd0);
            end
            if (!busy && pend_port.size() > 0) activate();
        end
    end

    // input driver: the active port serves the model's source queue, others carry noise
    always @(posedge clk) begin
        #1;
        kcnt++;
        if (ready_mode == 1) wr_ready = rpat[2'(kcnt % 4)];
        else                 wr_ready = ($urandom_range(0, 99) < ready_pct);
        for (int i = 0; i < int'(NP); i++) begin
            if (busy && i == act) begin
                in_valid[i]         = (src_data.size() > 0) && ($urandom_range(0, 99) < valid_pct);
                in_data[i*W +: W]   = (src_data.size() > 0) ? src_data[0] : '0;
                in_eop[i]           = (src_data.size() > 0) ? src_eop[0] : 1'b0;
            end else begin
                in_valid[i]         = 1'($urandom);
                in_data[i*W +: W]   = $urandom;
                in_eop[i]           = 1'($urandom);
            end
        end
    end

    task automatic grant(input int p, input int len, output int gc);
        sop    = NP'(1) << p;
        select = 4'(p);
        pend_port.push_back(p);
        pend_len.push_back(len);
        gc = cyc;
        @(posedge clk); #1;
        sop    = '0;
        select = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_cnt < n; i++) @(posedge clk);
        #1;
        chk("done_count", 64'(done_cnt), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 4-word packet on port 3, source and sink always ready
        grant(3, 4, g);
        wait_done(1, 50);
        chk("t1_port", 64'(last_done_port), 64'd3);
        chk("t1_len", 64'(last_done_len), 64'd4);
        chk("t1_trunc", 64'(last_done_trunc), 64'd0);
        chk("t1_first_valid", 64'(first_wv_cyc - g), 64'd2);
        chk("t1_hold_rise", 64'(hold_rise_cyc - g), 64'd1);
        chk("t1_sop_cyc", 64'(last_sop_cyc - g), 64'd2);
        chk("t1_eop_cyc", 64'(last_eop_cyc - g), 64'd5);
        chk("t1_done_cyc", 64'(done_cyc - g), 64'd6);
        @(posedge clk); #1;
        chk("t1_hold_fall", 64'(hold_fall_cyc - done_cyc), 64'd1);

        // single-word packet completes in cycle 3
        grant(5, 1, g);
        wait_done(2, 50);
        chk("one_word_done_cyc", 64'(done_cyc - g), 64'd3);

        // 5 words (= max_len) with wr_ready 1,0,0,1...
        ready_mode = 1;
        grant(2, 5, g);
        wait_done(3, 100);
        chk("t2_len", 64'(last_done_len), 64'd5);
        chk("t2_trunc", 64'(last_done_trunc), 64'd0);

        // 7 words truncated to 5, two drained
        ready_mode = 0;
        grant(6, 7, g);
        wait_done(4, 100);
        chk("t3_len", 64'(last_done_len), 64'd5);
        chk("t3_trunc", 64'(last_done_trunc), 64'd1);
        chk("t3_drained", 64'(drain_cnt), 64'd2);

        // out-of-range select, then select without its sop bit
        sop = 8'hFF; select = 4'd12;
        repeat (3) begin
            @(negedge clk);
            chk("bad_sel_hold", 64'(arb_hold), 64'd0);
            chk("bad_sel_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        sop = 8'hF7; select = 4'd3;
        repeat (3) begin
            @(negedge clk);
            chk("nosop_hold", 64'(arb_hold), 64'd0);
            chk("nosop_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        sop = '0;

        // back-to-back: port 1 then port 2, select moves mid-packet
        grant(1, 3, g);
        sop = 8'h06; select = 4'd2;
        pend_port.push_back(2);
        pend_len.push_back(2);
        wait_done(5, 100);
        eop1 = last_eop_cyc;
        chk("b2b_port1", 64'(last_done_port), 64'd1);
        @(posedge clk); #1;
        sop = '0;
        wait_done(6, 100);
        chk("b2b_gap_cycles", 64'(last_sop_cyc - eop1 - 1), 64'd3);
        chk("b2b_port2", 64'(last_done_port), 64'd2);

        // reset in the middle of a transfer
        grant(4, 6, g);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_async", 64'({in_ready, arb_hold, wr_valid, wr_sop, wr_eop, wr_port,
                              done_valid, done_port, done_len, done_trunc}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_rst", 64'(done_cnt), 64'd6);
        grant(6, 2, g);
        wait_done(7, 50);
        chk("post_rst_port", 64'(last_done_port), 64'd6);
        chk("post_rst_len", 64'(last_done_len), 64'd2);

        // randomised traffic with stalls and ignored selects
        ready_pct = 60;
        valid_pct = 70;
        for (int k = 0; k < 30; k++) begin
            int p, l;
            p = int'($urandom_range(0, NP - 1));
            l = int'($urandom_range(1, 8));
            if ($urandom_range(0, 2) == 0) begin
                sop    = NP'($urandom) | NP'(1);
                select = 4'($urandom_range(8, 15));
                repeat (2) @(posedge clk);
                #1 sop = '0;
            end
            grant(p, l, g);
            wait_done(8 + k, 400);
        end
        chk("final_pending", 64'(pend_port.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
